// File: rtl/pulse_meter_pkg.sv
// Shared types for the pulse interval meter.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } meter_state_t;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for an asynchronous pulse level.
module pulse_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic strobe
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign strobe = sync_r & ~prev_r;

endmodule

// File: rtl/pulse_interval_meter.sv
// Measures clk cycles between strobes on pulse_in and flags missing pulses with a timeout.
// Define PULSE_SYNC_EN to treat pulse_in as an asynchronous level (synchronized, rising edge).
module pulse_interval_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};

    if ((TIMEOUT < 1) || (TIMEOUT > ((2 ** WIDTH) - 1))) begin : g_timeout_range
        $error("pulse_interval_meter: TIMEOUT must lie in 1 .. 2**WIDTH-1");
    end

    logic strobe_s;

`ifdef PULSE_SYNC_EN
    pulse_sync_edge u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (pulse_in),
        .strobe   (strobe_s)
    );
`else
    assign strobe_s = pulse_in;
`endif

    meter_state_t     state_r;
    meter_state_t     state_nx_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nx_s;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] period_nx_s;
    logic             valid_r;
    logic             valid_nx_s;
    logic             timeout_r;
    logic             timeout_nx_s;

    // Next-state, counter and output computation
    always_comb begin
        state_nx_s   = state_r;
        count_nx_s   = count_r;
        period_nx_s  = period_r;
        valid_nx_s   = 1'b0;
        timeout_nx_s = timeout_r;
        if (!enable) begin
            state_nx_s   = IDLE;
            count_nx_s   = ZERO_C;
            timeout_nx_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (strobe_s) begin
                        state_nx_s = MEASURE;
                        count_nx_s = ONE_C;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                MEASURE: begin
                    // A strobe on the timeout cycle still counts as a valid interval
                    if (strobe_s) begin
                        period_nx_s = count_r;
                        valid_nx_s  = 1'b1;
                        count_nx_s  = ONE_C;
                    end else if (count_r == TIMEOUT_C) begin
                        state_nx_s   = STALLED;
                        timeout_nx_s = 1'b1;
                    end else begin
                        count_nx_s = count_r + ONE_C;
                    end
                end
                STALLED: begin
                    // Interval since the last pulse is unknown, so no period is reported
                    if (strobe_s) begin
                        state_nx_s   = MEASURE;
                        count_nx_s   = ONE_C;
                        timeout_nx_s = 1'b0;
                    end else begin
                        state_nx_s = STALLED;
                    end
                end
                default: begin
                    state_nx_s   = IDLE;
                    count_nx_s   = ZERO_C;
                    timeout_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            count_r   <= ZERO_C;
            period_r  <= ZERO_C;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            count_r   <= count_nx_s;
            period_r  <= period_nx_s;
            valid_r   <= valid_nx_s;
            timeout_r <= timeout_nx_s;
        end
    end

    assign period       = period_r;
    assign period_valid = valid_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Scoreboard bench for pulse_interval_meter against a time-stamp based reference model.
module tb_pulse_interval_meter;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 50;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic             pulse_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             timeout;

    pulse_interval_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .pulse_in     (pulse_in),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] p;
        logic             to;
    } exp_t;

    exp_t q[$];
    int   tests   = 0;
    int   fails   = 0;
    bit   started = 1'b0;

    // Reference model: strobe time stamps, not a counter
    int               cyc         = 0;
    int               last_t      = 0;
    bit               have        = 1'b0;
    bit               stalled     = 1'b0;
    logic [WIDTH-1:0] last_period = '0;
    logic             h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic drive(input logic en, input logic p);
        logic s;
        exp_t x;
        @(negedge clk);
        reset_n  = 1'b1;
        enable   = en;
        pulse_in = p;
`ifdef PULSE_SYNC_EN
        s  = h2 & ~h3;
        h3 = h2;
        h2 = h1;
        h1 = p;
`else
        s = p;
`endif
        x.v = 1'b0;
        if (!en) begin
            have    = 1'b0;
            stalled = 1'b0;
        end else if (s) begin
            if (have && !stalled) begin
                x.v         = 1'b1;
                last_period = WIDTH'(cyc - last_t);
            end
            have    = 1'b1;
            stalled = 1'b0;
            last_t  = cyc;
        end else if (have && !stalled && ((cyc - last_t) == TIMEOUT)) begin
            stalled = 1'b1;
        end
        x.p  = last_period;
        x.to = stalled;
        q.push_back(x);
        cyc++;
    endtask

    task automatic strobe_after(input int n, input logic en = 1'b1);
        for (int i = 1; i < n; i++) drive(en, 1'b0);
        drive(en, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock
    task automatic do_reset();
        exp_t x;
        @(negedge clk);
        enable   = 1'b1;
        pulse_in = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("reset_period", period, '0);
        check("reset_valid", {{(WIDTH-1){1'b0}}, period_valid}, '0);
        check("reset_timeout", {{(WIDTH-1){1'b0}}, timeout}, '0);
        have        = 1'b0;
        stalled     = 1'b0;
        last_period = '0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        x.v = 1'b0; x.p = '0; x.to = 1'b0;
        q.push_back(x);
        cyc++;
        started = 1'b1;
    endtask

    // Monitor: one expectation per sampled clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("period_valid", {{(WIDTH-1){1'b0}}, period_valid}, {{(WIDTH-1){1'b0}}, e.v});
                check("timeout", {{(WIDTH-1){1'b0}}, timeout}, {{(WIDTH-1){1'b0}}, e.to});
                check("period", period, e.p);
            end else if (started) begin
                tests++;
                fails++;
                $display("FAIL no_expectation at cycle %0d: got valid=%0b, expected a queued entry", cyc, period_valid);
            end
        end
    end

    initial begin
        reset_n  = 1'b1;
        enable   = 1'b0;
        pulse_in = 1'b0;
        do_reset();
        idle(3);
        // back-to-back strobes
        for (int i = 0; i < 10; i++) strobe_after(1);
        for (int i = 0; i < 3; i++) strobe_after(30);
        // spacing exactly at the timeout limit
        for (int i = 0; i < 3; i++) strobe_after(TIMEOUT);
        // pulses stop, recover, then a 20-cycle interval
        idle(60);
        strobe_after(5);
        strobe_after(20);
        strobe_after(TIMEOUT + 1);
        strobe_after(12);
        // enable dropped mid-measure with strobes ignored
        strobe_after(10);
        for (int i = 0; i < 3; i++) strobe_after(4, 1'b0);
        strobe_after(7);
        strobe_after(7);
        // level held high
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1);
        idle(10);
        strobe_after(9);
        // reset mid-measure
        strobe_after(10);
        idle(5);
        do_reset();
        strobe_after(3);
        strobe_after(3);
        strobe_after(3);
        // randomized intervals with occasional enable drops
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 5)); k++)
                    drive(1'b0, 1'($urandom_range(0, 1)));
            end
            strobe_after(int'($urandom_range(1, TIMEOUT + 20)));
        end
        idle(2);
        @(negedge clk);
        started = 1'b0;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
